// File: rtl/skeleton_test.sv
// Two-clock-per-instruction 32-bit processor with built-in program ROM,
// register file, data RAM and per-instruction debug outputs.
module skeleton_test (
    input  logic        clock,
    input  logic        ctrl_reset,
    output logic        imem_clock,
    output logic        dmem_clock,
    output logic        processor_clock,
    output logic        regfile_clock,
    output logic [31:0] data_readRegA,
    output logic [31:0] data_readRegB,
    output logic [31:0] q_dmem
);

    localparam int unsigned IMEM_DEPTH = 16;
    localparam int unsigned DMEM_DEPTH = 16;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_N      = 32;
    localparam int unsigned RIDX_W     = 5;
    localparam int unsigned IA_W       = $clog2(IMEM_DEPTH);
    localparam int unsigned PC_W       = IA_W + 1;
    localparam int unsigned DA_W       = $clog2(DMEM_DEPTH);
    localparam int unsigned IMM_W      = 17;

    localparam logic [PC_W-1:0] PC_END = PC_W'(IMEM_DEPTH);

    localparam logic [0:0] PH_FETCH = 1'b0;
    localparam logic [0:0] PH_EXEC  = 1'b1;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;

    // R-type instruction word builder
    function automatic logic [XLEN-1:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [4:0] shamt,
                                              input logic [4:0] aluop);
        return {OP_R, rd, rs, rt, shamt, aluop, 2'b00};
    endfunction

    // I-type instruction word builder
    function automatic logic [XLEN-1:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs, input logic [IMM_W-1:0] imm);
        return {op, rd, rs, imm};
    endfunction

    logic [0:0]      phase;
    logic [0:0]      phase_nxt;
    logic [PC_W-1:0] pc;
    logic            proc_clk;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] regs [REG_N];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];

    logic [XLEN-1:0]   rom_c;
    logic [RIDX_W-1:0] f_rs_c;
    logic [RIDX_W-1:0] f_b_idx_c;
    logic [XLEN-1:0]   fetch_a_c;
    logic [XLEN-1:0]   fetch_b_c;

    logic [4:0]        opcode_c;
    logic [RIDX_W-1:0] rd_c;
    logic [4:0]        shamt_c;
    logic [4:0]        aluop_c;
    logic [XLEN-1:0]   imm_sext_c;
    logic [XLEN-1:0]   ea_c;
    logic [DA_W-1:0]   daddr_c;
    logic [XLEN-1:0]   res_c;
    logic              rf_we_c;
    logic              mem_we_c;
    logic [XLEN-1:0]   dbg_a_c;
    logic [XLEN-1:0]   dbg_b_c;
    logic [XLEN-1:0]   dbg_q_c;
    logic              unused_ea;

    assign imem_clock      = clock;
    assign dmem_clock      = clock;
    assign processor_clock = proc_clk;
    assign regfile_clock   = proc_clk;

    // Phase register: fetch/decode alternates with execute/retire
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) phase <= PH_FETCH;
        else             phase <= phase_nxt;
    end

    // Next-phase logic
    always_comb begin
        phase_nxt = phase;
        case (phase)
            PH_FETCH: phase_nxt = PH_EXEC;
            default:  phase_nxt = PH_FETCH;
        endcase
    end

    // Divided clock, high during the execute phase
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) proc_clk <= 1'b0;
        else             proc_clk <= ~proc_clk;
    end

    // Fixed program ROM; past the end it reads as nop
    always_comb begin
        rom_c = '0;
        if (pc < PC_END) begin
            case (pc[IA_W-1:0])
                4'd0:    rom_c = enc_i(OP_ADDI, 5'd1,  5'd0, 17'd5);
                4'd1:    rom_c = enc_i(OP_ADDI, 5'd2,  5'd0, 17'd3);
                4'd2:    rom_c = enc_r(5'd3, 5'd1, 5'd2, 5'd0, ALU_ADD);
                4'd3:    rom_c = enc_r(5'd4, 5'd1, 5'd2, 5'd0, ALU_SUB);
                4'd4:    rom_c = enc_r(5'd5, 5'd4, 5'd1, 5'd0, ALU_AND);
                4'd5:    rom_c = enc_r(5'd6, 5'd2, 5'd0, 5'd1, ALU_SRA);
                4'd6:    rom_c = enc_r(5'd7, 5'd4, 5'd6, 5'd0, ALU_OR);
                4'd7:    rom_c = enc_r(5'd8, 5'd1, 5'd0, 5'd2, ALU_SLL);
                4'd8:    rom_c = enc_i(OP_ADDI, 5'd9,  5'd6, 17'd3);
                4'd9:    rom_c = enc_i(OP_ADDI, 5'd10, 5'd0, 17'd345);
                4'd10:   rom_c = enc_i(OP_ADDI, 5'd11, 5'd0, 17'd567);
                4'd11:   rom_c = enc_i(OP_SW,   5'd10, 5'd0, 17'd0);
                4'd12:   rom_c = enc_i(OP_SW,   5'd11, 5'd0, 17'd1);
                4'd13:   rom_c = enc_i(OP_LW,   5'd12, 5'd0, 17'd0);
                4'd14:   rom_c = enc_i(OP_LW,   5'd13, 5'd0, 17'd1);
                default: rom_c = '0;
            endcase
        end
    end

    // Operand read at decode: rs always, rt for R-type, rd (store data) otherwise
    always_comb begin
        f_rs_c    = rom_c[21:17];
        f_b_idx_c = (rom_c[31:27] == OP_R) ? rom_c[16:12] : rom_c[26:22];
        fetch_a_c = regs[f_rs_c];
        fetch_b_c = regs[f_b_idx_c];
    end

    // Execute: ALU, effective address, writeback enables and debug values
    always_comb begin
        opcode_c   = ir[31:27];
        rd_c       = ir[26:22];
        shamt_c    = ir[11:7];
        aluop_c    = ir[6:2];
        imm_sext_c = {{(XLEN-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
        ea_c       = op_a + imm_sext_c;
        daddr_c    = ea_c[DA_W-1:0];
        res_c      = '0;
        rf_we_c    = 1'b0;
        mem_we_c   = 1'b0;
        dbg_a_c    = '0;
        dbg_b_c    = '0;
        dbg_q_c    = '0;
        if (ir != '0) begin
            case (opcode_c)
                OP_R: begin
                    dbg_a_c = ir;
                    rf_we_c = 1'b1;
                    case (aluop_c)
                        ALU_ADD: res_c = op_a + op_b;
                        ALU_SUB: res_c = op_a - op_b;
                        ALU_AND: res_c = op_a & op_b;
                        ALU_OR:  res_c = op_a | op_b;
                        ALU_SLL: res_c = op_a << shamt_c;
                        ALU_SRA: res_c = XLEN'($signed(op_a) >>> shamt_c);
                        default: begin
                            res_c   = '0;
                            rf_we_c = 1'b0;
                        end
                    endcase
                    dbg_b_c = res_c;
                end
                OP_ADDI: begin
                    dbg_a_c = ir;
                    res_c   = ea_c;
                    rf_we_c = 1'b1;
                    dbg_b_c = res_c;
                end
                OP_SW: begin
                    dbg_a_c  = ir;
                    mem_we_c = 1'b1;
                    dbg_b_c  = op_b;
                    dbg_q_c  = op_b;
                end
                OP_LW: begin
                    dbg_a_c = ir;
                    res_c   = dmem[daddr_c];
                    rf_we_c = 1'b1;
                    dbg_b_c = res_c;
                    dbg_q_c = res_c;
                end
                default: ;
            endcase
        end
        if (rd_c == '0) rf_we_c = 1'b0;
    end

    assign unused_ea = ^ea_c[XLEN-1:DA_W];

    // Architectural state: PC, pipeline latches, register file, data RAM, debug
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            pc            <= '0;
            ir            <= '0;
            op_a          <= '0;
            op_b          <= '0;
            data_readRegA <= '0;
            data_readRegB <= '0;
            q_dmem        <= '0;
            for (int unsigned i = 0; i < REG_N; i++)      regs[RIDX_W'(i)] <= '0;
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem[DA_W'(i)]   <= '0;
        end else if (phase == PH_FETCH) begin
            ir   <= rom_c;
            op_a <= fetch_a_c;
            op_b <= fetch_b_c;
        end else begin
            if (pc < PC_END) pc <= pc + PC_W'(1);
            if (rf_we_c)     regs[rd_c] <= res_c;
            if (mem_we_c)    dmem[daddr_c] <= op_b;
            data_readRegA <= dbg_a_c;
            data_readRegB <= dbg_b_c;
            q_dmem        <= dbg_q_c;
        end
    end

endmodule

// File: tb/tb_skeleton_test.sv
// Bench for skeleton_test: ISA-level interpreter of the program predicts the
// retirement stream; resets are injected at random points.
module tb_skeleton_test;

    localparam int K_NOP = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_OR = 4,
                   K_SLL = 5, K_SRA = 6, K_ADDI = 7, K_SW = 8, K_LW = 9;

    typedef struct {
        int kind;
        int rd;
        int rs;
        int rt;
        int sh;
        int imm;
    } ins_t;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic        imem_clock, dmem_clock, processor_clock, regfile_clock;
    logic [31:0] data_readRegA, data_readRegB, q_dmem;

    int n_chk  = 0;
    int n_pass = 0;

    ins_t        prog  [16];
    logic [31:0] exp_a [16];
    logic [31:0] exp_b [16];
    logic [31:0] exp_q [16];

    skeleton_test dut (
        .clock           (clock),
        .ctrl_reset      (ctrl_reset),
        .imem_clock      (imem_clock),
        .dmem_clock      (dmem_clock),
        .processor_clock (processor_clock),
        .regfile_clock   (regfile_clock),
        .data_readRegA   (data_readRegA),
        .data_readRegB   (data_readRegB),
        .q_dmem          (q_dmem)
    );

    always #5 clock = ~clock;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                      tag, obs, obs, exp, exp, $time);
    endtask

    // Run the program through an ISA-level interpreter
    task automatic build_model();
        logic [31:0] r [32];
        logic [31:0] m [16];
        logic [31:0] a, b, res, imm32;
        int unsigned addr;
        foreach (r[i]) r[i] = '0;
        foreach (m[i]) m[i] = '0;
        prog[0]  = '{K_ADDI, 1, 0, 0, 0, 5};
        prog[1]  = '{K_ADDI, 2, 0, 0, 0, 3};
        prog[2]  = '{K_ADD,  3, 1, 2, 0, 0};
        prog[3]  = '{K_SUB,  4, 1, 2, 0, 0};
        prog[4]  = '{K_AND,  5, 4, 1, 0, 0};
        prog[5]  = '{K_SRA,  6, 2, 0, 1, 0};
        prog[6]  = '{K_OR,   7, 4, 6, 0, 0};
        prog[7]  = '{K_SLL,  8, 1, 0, 2, 0};
        prog[8]  = '{K_ADDI, 9, 6, 0, 0, 3};
        prog[9]  = '{K_ADDI, 10, 0, 0, 0, 345};
        prog[10] = '{K_ADDI, 11, 0, 0, 0, 567};
        prog[11] = '{K_SW,   10, 0, 0, 0, 0};
        prog[12] = '{K_SW,   11, 0, 0, 0, 1};
        prog[13] = '{K_LW,   12, 0, 0, 0, 0};
        prog[14] = '{K_LW,   13, 0, 0, 0, 1};
        prog[15] = '{K_NOP,  0, 0, 0, 0, 0};
        for (int k = 0; k < 16; k++) begin
            ins_t in;
            in = prog[k];
            a = r[in.rs];
            b = r[in.rt];
            imm32 = 32'(in.imm);
            exp_a[k] = '0; exp_b[k] = '0; exp_q[k] = '0;
            case (in.kind)
                K_ADD, K_SUB, K_AND, K_OR, K_SLL, K_SRA: begin
                    case (in.kind)
                        K_ADD:   res = a + b;
                        K_SUB:   res = a - b;
                        K_AND:   res = a & b;
                        K_OR:    res = a | b;
                        K_SLL:   res = a * (32'd1 << in.sh);
                        default: res = 32'($signed(a) >>> in.sh);
                    endcase
                    exp_a[k] = {5'd0, 5'(in.rd), 5'(in.rs), 5'(in.rt), 5'(in.sh),
                                5'(in.kind - K_ADD), 2'b00};
                    exp_b[k] = res;
                    if (in.rd != 0) r[in.rd] = res;
                end
                K_ADDI: begin
                    res = a + imm32;
                    exp_a[k] = {5'b00101, 5'(in.rd), 5'(in.rs), 17'(in.imm)};
                    exp_b[k] = res;
                    if (in.rd != 0) r[in.rd] = res;
                end
                K_SW: begin
                    addr = (a + imm32) % 16;
                    m[addr] = r[in.rd];
                    exp_a[k] = {5'b00111, 5'(in.rd), 5'(in.rs), 17'(in.imm)};
                    exp_b[k] = r[in.rd];
                    exp_q[k] = m[addr];
                end
                K_LW: begin
                    addr = (a + imm32) % 16;
                    res = m[addr];
                    exp_a[k] = {5'b01000, 5'(in.rd), 5'(in.rs), 17'(in.imm)};
                    exp_b[k] = res;
                    exp_q[k] = res;
                    if (in.rd != 0) r[in.rd] = res;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] slot_a(input int k);
        return (k >= 0 && k < 16) ? exp_a[k] : 32'd0;
    endfunction
    function automatic logic [31:0] slot_b(input int k);
        return (k >= 0 && k < 16) ? exp_b[k] : 32'd0;
    endfunction
    function automatic logic [31:0] slot_q(input int k);
        return (k >= 0 && k < 16) ? exp_q[k] : 32'd0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},    data_readRegA, 32'd0);
        check({tag, "_b"},    data_readRegB, 32'd0);
        check({tag, "_q"},    q_dmem, 32'd0);
        check({tag, "_pclk"}, {31'd0, processor_clock}, 32'd0);
        check({tag, "_rclk"}, {31'd0, regfile_clock}, 32'd0);
    endtask

    // Entered right after reset release at a negedge; checks n retirements
    task automatic run_slots(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            check("imem_clk_hi", {31'd0, imem_clock}, 32'd1);
            check("dmem_clk_hi", {31'd0, dmem_clock}, 32'd1);
            @(negedge clock);
            check("imem_clk_lo", {31'd0, imem_clock}, 32'd0);
            check("pclk_exec",   {31'd0, processor_clock}, 32'd1);
            check("rclk_exec",   {31'd0, regfile_clock}, 32'd1);
            check($sformatf("hold_b%0d", k), data_readRegB, slot_b(k - 1));
            @(negedge clock);
            check("pclk_retire", {31'd0, processor_clock}, 32'd0);
            check($sformatf("slot%0d_a", k), data_readRegA, slot_a(k));
            check($sformatf("slot%0d_b", k), data_readRegB, slot_b(k));
            check($sformatf("slot%0d_q", k), q_dmem, slot_q(k));
        end
    endtask

    // Asynchronous reset at a random point inside a cycle, released at a negedge
    task automatic reset_mid();
        repeat ($urandom_range(0, 1)) @(posedge clock);
        @(posedge clock);
        #($urandom_range(1, 4));
        ctrl_reset = 1'b0;
        #1;
        check_all_zero("rst_now");
        repeat ($urandom_range(1, 4)) @(negedge clock);
        check_all_zero("rst_hold");
        ctrl_reset = 1'b1;
    endtask

    initial begin
        build_model();
        ctrl_reset = 1'b0;
        repeat (4) @(negedge clock);
        check_all_zero("reset");
        ctrl_reset = 1'b1;
        run_slots(20);

        reset_mid();
        run_slots(7);
        reset_mid();
        run_slots(3);

        for (int t = 0; t < 4; t++) begin
            reset_mid();
            run_slots($urandom_range(3, 18));
        end

        reset_mid();
        run_slots(17);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/skeleton_test.md
Name: skeleton_test

Overview:
- Self-contained single-cycle-issue, two-clock-per-instruction 32-bit processor, after the ECE550 ISA subset.
- Contains a fixed 16-word instruction ROM, 32x32 register file, 16-word data RAM and derived clock outputs.
- Exposes per-instruction debug results for bench checking; top-level test harness block.

Parameters:
- IMEM_DEPTH, 16, instruction ROM words; PC wraps never, halts past end.
- DMEM_DEPTH, 16, data RAM words; address uses low 4 bits of effective address.

Ports:
- clock  in  1  system clock, all state on rising edge.
- ctrl_reset  in  1  asynchronous, active-low reset.
- imem_clock  out  1  equals clock.
- dmem_clock  out  1  equals clock.
- processor_clock  out  1  clock/2, reset 0, toggles each rising edge.
- regfile_clock  out  1  equals processor_clock.
- data_readRegA  out  32  instruction word of last retired instruction (0 = none/nop).
- data_readRegB  out  32  result of last retired instruction: regfile write data, or store data for sw.
- q_dmem  out  32  data RAM read data of last retired lw/sw address (0 otherwise).
- One clock; reset is asynchronous and active-low.

Behaviour:
- Reset (ctrl_reset=0): PC=0, phase=0, all regs, data RAM, debug outputs and processor_clock = 0.
- Phase bit toggles each edge: phase0 fetch/decode, phase1 execute + writeback + debug update; one instruction retires every 2 clocks.
- Instruction k result appears on debug outputs at the 2(k+1)th rising edge after reset release; holds until next retirement.
- Format: opcode[31:27], rd[26:22], rs[21:17]; R-type rt[16:12], shamt[11:7], aluop[6:2]; I-type imm[16:0] sign-extended.
- Opcodes: 00000 R, 00101 addi, 00111 sw (mem[rs+imm]<=rd), 01000 lw (rd<=mem[rs+imm]); others = nop.
- aluop: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll by shamt, 00101 sra by shamt; others -> result 0, no write.
- Arithmetic 32-bit two's complement, wraps on overflow, no exceptions.
- r0 reads 0; writes to r0 ignored (debug still shows computed result).
- Word 0x00000000 is nop: debug A/B/q_dmem driven 0, PC advances.
- PC >= 16: ROM returns 0; processor idles emitting nops forever.
- Reset mid-instruction: abort instantly, restart at PC 0.
- ROM program (addr: instr -> data_readRegB):
  0 addi r1,r0,5 -> 5; 1 addi r2,r0,3 -> 3; 2 add r3,r1,r2 -> 8; 3 sub r4,r1,r2 -> 2;
  4 and r5,r4,r1 -> 0; 5 sra r6,r2,1 -> 1; 6 or r7,r4,r6 -> 3; 7 sll r8,r1,2 -> 20;
  8 addi r9,r6,3 -> 4; 9 addi r10,r0,345 -> 345; 10 addi r11,r0,567 -> 567;
  11 sw r10,0(r0) -> 345; 12 sw r11,1(r0) -> 567; 13 lw r12,0(r0) -> 345; 14 lw r13,1(r0) -> 567; 15 nop.

Test Plan:
- Hold ctrl_reset=0 several cycles -> all data outputs 0, processor_clock 0; release at negedge.
- Release reset; sample every 2 negedges -> data_readRegB sequence 5,3,8,2,0,1,3,20,4,345,567,345,567 with data_readRegA nonzero each time.
- Continue -> slots 13/14 give data_readRegB and q_dmem 345 then 567; slot 15 onward all debug outputs 0.
- Check imem_clock/dmem_clock track clock; processor_clock/regfile_clock period 2x clock, in phase with retirement.
- Assert ctrl_reset low mid-program (after slot 6) -> outputs 0 immediately; release -> sequence restarts at 5.
